// File: rtl/r_clk_fwft_reader_if.sv
//==============================================================================
// Module      : r_clk_fwft_reader_if
// Description : Bundle of the FIFO read-side controller's ports: write-pointer
//               input, read pointer/address/strobe towards the memory, and the
//               valid/ready output stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface r_clk_fwft_reader_if #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_SIZE    = 8
);
    logic [ADDRESS_SIZE:0]   w_ptr;
    logic [ADDRESS_SIZE:0]   r_ptr;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic                    r_en_mem;
    logic [DATA_SIZE-1:0]    r_data_mem;
    logic [DATA_SIZE-1:0]    r_data;
    logic                    r_valid;
    logic                    r_ready;
    logic                    r_empty;
    logic [ADDRESS_SIZE:0]   r_level;

    modport master (
        input  w_ptr, r_data_mem, r_ready,
        output r_ptr, r_addr, r_en_mem, r_data, r_valid, r_empty, r_level
    );

    modport slave (
        output w_ptr, r_data_mem, r_ready,
        input  r_ptr, r_addr, r_en_mem, r_data, r_valid, r_empty, r_level
    );
endinterface

`default_nettype wire

// File: rtl/r_clk_fwft_reader.sv
//==============================================================================
// Module      : r_clk_fwft_reader
// Description : Async FIFO read-side controller with a 2-entry prefetch stage
//               giving a first-word-fall-through valid/ready output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module r_clk_fwft_reader #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_SIZE    = 8
) (
    input  wire logic            r_clk,
    input  wire logic            rrst_n,
    r_clk_fwft_reader_if.master  bus
);

    function automatic logic [ADDRESS_SIZE:0] bin2gray(input logic [ADDRESS_SIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDRESS_SIZE:0] gray2bin(input logic [ADDRESS_SIZE:0] g);
        logic [ADDRESS_SIZE:0] b;
        b = '0;
        for (int i = 0; i <= ADDRESS_SIZE; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [ADDRESS_SIZE:0]  rq1_wptr;
    logic [ADDRESS_SIZE:0]  rq2_wptr;
    logic [ADDRESS_SIZE:0]  bin_q;
    logic [ADDRESS_SIZE:0]  ptr_q;
    logic [ADDRESS_SIZE:0]  bnext;
    logic                   empty_q;
    logic [ADDRESS_SIZE:0]  level_q;

    logic                   inflight;
    logic                   head_valid;
    logic [DATA_SIZE-1:0]   head_data;
    logic                   skid_valid;
    logic [DATA_SIZE-1:0]   skid_data;

    logic                   head_valid_n;
    logic [DATA_SIZE-1:0]   head_data_n;
    logic                   skid_valid_n;
    logic [DATA_SIZE-1:0]   skid_data_n;

    logic [1:0]             occ;
    logic                   pop;
    logic                   issue;

    // occ counts the in-flight read so the stage can never be over-committed
    assign occ   = {1'b0, head_valid} + {1'b0, skid_valid} + {1'b0, inflight};
    assign pop   = head_valid & bus.r_ready;
    assign issue = !empty_q && ((occ - {1'b0, pop}) < 2'd2);
    assign bnext = bin_q + {{ADDRESS_SIZE{1'b0}}, issue};

    assign bus.r_ptr    = ptr_q;
    assign bus.r_addr   = bin_q[ADDRESS_SIZE-1:0];
    assign bus.r_en_mem = issue;
    assign bus.r_data   = head_data;
    assign bus.r_valid  = head_valid;
    assign bus.r_empty  = empty_q;
    assign bus.r_level  = level_q;

    always_comb begin
        head_valid_n = head_valid;
        head_data_n  = head_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (pop) begin
            head_valid_n = skid_valid;
            head_data_n  = skid_valid ? skid_data : head_data;
            skid_valid_n = 1'b0;
        end
        // Returning word takes the first free slot after the pop is applied
        if (inflight) begin
            if (!head_valid_n) begin
                head_valid_n = 1'b1;
                head_data_n  = bus.r_data_mem;
            end else begin
                skid_valid_n = 1'b1;
                skid_data_n  = bus.r_data_mem;
            end
        end
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1_wptr   <= '0;
            rq2_wptr   <= '0;
            bin_q      <= '0;
            ptr_q      <= '0;
            empty_q    <= 1'b1;
            level_q    <= '0;
            inflight   <= 1'b0;
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            rq1_wptr   <= bus.w_ptr;
            rq2_wptr   <= rq1_wptr;
            bin_q      <= bnext;
            ptr_q      <= bin2gray(bnext);
            empty_q    <= (bin2gray(bnext) == rq2_wptr);
            level_q    <= gray2bin(rq2_wptr) - bnext;
            inflight   <= issue;
            head_valid <= head_valid_n;
            head_data  <= head_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
        end
    end

endmodule

`default_nettype wire
